pcs_tx_gearbox_66_64: RTL and testbench

//  TX 66b->64b gearbox, directly downstream of the 64-bit x^58+x^39+1 scrambler.

---
 rtl/pcs_pkg.sv | 30 +++
 rtl/pcs_sat_counter.sv | 19 +
 rtl/pcs_tx_gearbox_66_64.sv | 113 +++++++++++
 tb/tb_pcs_tx_gearbox_66_64.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS definitions: block/header geometry, gearbox sequence length
// and the per-cycle operation classification used by the TX gearbox.
package pcs_pkg;

    localparam int PCS_BLK_W  = 66;
    localparam int PCS_HDR_W  = 2;
    localparam int PCS_PAY_W  = PCS_BLK_W - PCS_HDR_W;
    localparam int PCS_GB_SEQ = 33;
    localparam int PCS_K_W    = 6;

    localparam logic [PCS_HDR_W-1:0] PCS_HDR_DATA = 2'b01;
    localparam logic [PCS_HDR_W-1:0] PCS_HDR_CTRL = 2'b10;

    typedef logic [PCS_K_W-1:0] pcs_phase_t;

    // Phase at which the residual register holds a full word and must drain.
    localparam pcs_phase_t PCS_DRAIN_K = pcs_phase_t'(PCS_GB_SEQ - 1);

    typedef enum logic [1:0] {
        GB_HOLD,
        GB_IDLE,
        GB_ACCEPT,
        GB_DRAIN
    } pcs_gb_op_t;

    function automatic pcs_phase_t pcs_phase_inc(input pcs_phase_t k);
        return k + pcs_phase_t'(1);
    endfunction

endpackage

// File: rtl/pcs_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module pcs_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pcs_tx_gearbox_66_64.sv
// TX 66b->64b gearbox: packs header+payload blocks into a 64-bit PMA stream,
// draining the residual every 33rd enabled cycle. Optional macro PCS_TXGB_ERRCNT_EN
// adds a saturating violation counter on err_cnt.
module pcs_tx_gearbox_66_64
    import pcs_pkg::*;
#(
    parameter int OUT_W = 64,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_enable,
    input  logic                 in_pop,
    input  logic [PCS_HDR_W-1:0] in_header,
    input  logic [PCS_PAY_W-1:0] in_data,
    output logic                 in_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    output logic                 err,
    output logic [CNT_W-1:0]     err_cnt
);

    // A shifted block never reaches bit 2*OUT_W since k <= 31 whenever a block is accepted.
    localparam int CAT_W = 2 * OUT_W;

    generate
        if (OUT_W != 64) begin : g_out_w_check
            $error("pcs_tx_gearbox_66_64 supports only OUT_W = 64");
        end
    endgenerate

    pcs_phase_t           k;
    pcs_phase_t           k_next;
    logic [OUT_W-1:0]     res;
    logic [PCS_BLK_W-1:0] blk;
    logic [CAT_W-1:0]     cat;
    pcs_gb_op_t           op;
    logic                 violation;

    assign blk       = {in_data, in_header};
    assign cat       = ({{(CAT_W - PCS_BLK_W){1'b0}}, blk} << {k, 1'b0})
                     | {{(CAT_W - OUT_W){1'b0}}, res};
    assign violation = in_enable & in_pop & ~in_ready;

    always_comb begin
        op = GB_HOLD;
        if (in_enable) begin
            if (!in_ready) begin
                op = GB_DRAIN;
            end else if (in_pop) begin
                op = GB_ACCEPT;
            end else begin
                op = GB_IDLE;
            end
        end
    end

    always_comb begin
        k_next = k;
        unique case (op)
            GB_ACCEPT: k_next = pcs_phase_inc(k);
            GB_DRAIN:  k_next = '0;
            default:   k_next = k;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k         <= '0;
            res       <= '0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            k        <= k_next;
            // Registered look-ahead: the drain cycle is announced one cycle early.
            in_ready <= (k_next != PCS_DRAIN_K);
            if (violation) begin
                err <= 1'b1;
            end
            unique case (op)
                GB_ACCEPT: begin
                    out_data  <= cat[OUT_W-1:0];
                    res       <= cat[CAT_W-1:OUT_W];
                    out_valid <= 1'b1;
                end
                GB_DRAIN: begin
                    out_data  <= res;
                    res       <= '0;
                    out_valid <= 1'b1;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PCS_TXGB_ERRCNT_EN
    pcs_sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .clr  (~reset_n),
        .inc  (violation),
        .count(err_cnt)
    );
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pcs_tx_gearbox_66_64.sv
// Bench for pcs_tx_gearbox_66_64: bit-queue reference model plus per-scenario tasks.
module tb_pcs_tx_gearbox_66_64;
    import pcs_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_enable = 1'b0;
    logic             in_pop = 1'b0;
    logic [1:0]       in_header = 2'b00;
    logic [63:0]      in_data = 64'h0;
    logic             in_ready;
    logic [63:0]      out_data;
    logic             out_valid;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    pcs_tx_gearbox_66_64 #(.OUT_W(64), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_enable(in_enable),
        .in_pop   (in_pop),
        .in_header(in_header),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: the wire is a FIFO of bits; each output word takes the next 64.
    bit               mq[$];
    int               nblk = 0;
    logic [63:0]      exp_word = 64'h0;
    logic             exp_valid = 1'b0;
    logic             exp_ready = 1'b1;
    logic             exp_err = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic drive(input logic en, input logic pop, input logic [1:0] hdr, input logic [63:0] data);
        logic [65:0] blk;
        logic [63:0] w;
        in_enable = en;
        in_pop    = pop;
        in_header = hdr;
        in_data   = data;
        blk       = {data, hdr};
        w         = 64'h0;
        if (!reset_n) begin
            mq.delete();
            nblk = 0; exp_word = 64'h0; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = '0;
        end else if (!en) begin
            exp_valid = 1'b0;
        end else if (nblk == PCS_GB_SEQ - 1) begin
            for (int b = 0; b < 64; b++) w[b] = mq.pop_front();
            exp_word = w; exp_valid = 1'b1; nblk = 0;
            if (pop) begin
                exp_err = 1'b1;
`ifdef PCS_TXGB_ERRCNT_EN
                if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
`endif
            end
        end else if (pop) begin
            for (int b = 0; b < 66; b++) mq.push_back(blk[b]);
            for (int b = 0; b < 64; b++) w[b] = mq.pop_front();
            exp_word = w; exp_valid = 1'b1; nblk++;
        end else begin
            exp_valid = 1'b0;
        end
        exp_ready = (nblk != PCS_GB_SEQ - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b1, PCS_HDR_CTRL, {$urandom, $urandom});
        drive(1'b0, 1'b0, PCS_HDR_DATA, 64'h0);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1 || err !== 1'b0 || err_cnt !== '0) begin
            fails++;
            $display("FAIL reset: valid=%b data=%h ready=%b err=%b cnt=%0d, want 0 0 1 0 0",
                     out_valid, out_data, in_ready, err, err_cnt);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_zero_blocks();
        logic [63:0] want;
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, i < 32, PCS_HDR_DATA, 64'h0);
            checks++;
            if (out_data !== exp_word || out_valid !== exp_valid || in_ready !== exp_ready || err !== exp_err || err_cnt !== exp_cnt) begin
                fails++;
                $display("FAIL zero_blk[%0d]: data=%h valid=%b ready=%b err=%b cnt=%0d, want %h %b %b %b %0d",
                         i, out_data, out_valid, in_ready, err, err_cnt, exp_word, exp_valid, exp_ready, exp_err, exp_cnt);
            end
            // Header of block i sits at stream bit 66*i, i.e. bit 2*i of word i; the drain word is all payload zeros.
            want = (i < 32) ? (64'd1 << (2 * i)) : 64'd0;
            checks++;
            if (out_data !== want || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL zero_word[%0d]: got %h valid=%b, want %h valid=1", i, out_data, out_valid, want);
            end
            if (i == 31) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL zero_ready_drop: in_ready=%b, want 0", in_ready);
                end
            end
        end
    endtask

    task automatic test_incrementing();
        bit          sent[$];
        bit          got[$];
        logic [1:0]  hdr;
        logic [65:0] blk;
        int          bad;
        for (int i = 0; i < 33; i++) begin
            hdr = (i % 2 == 1) ? PCS_HDR_CTRL : PCS_HDR_DATA;
            blk = {64'(i), hdr};
            if (i < 32) for (int b = 0; b < 66; b++) sent.push_back(blk[b]);
            drive(1'b1, i < 32, hdr, 64'(i));
            if (out_valid === 1'b1) for (int b = 0; b < 64; b++) got.push_back(out_data[b]);
            checks++;
            if (out_data !== exp_word || out_valid !== exp_valid || in_ready !== exp_ready) begin
                fails++;
                $display("FAIL incr[%0d]: data=%h valid=%b ready=%b, want %h %b %b",
                         i, out_data, out_valid, in_ready, exp_word, exp_valid, exp_ready);
            end
        end
        bad = 0;
        if (got.size() != 2112 || sent.size() != 2112) bad = 1;
        else for (int b = 0; b < 2112; b++) if (got[b] != sent[b]) bad = 1;
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL incr_stream: got %0d bits, want 2112 bits identical to sent blocks", got.size());
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL incr_ready_after: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_idle_gap();
        logic pop;
        for (int c = 0; c < 38; c++) begin
            pop = !(c >= 7 && c < 12) && (c < 37);
            drive(1'b1, pop, ($urandom_range(0, 1) == 1) ? PCS_HDR_CTRL : PCS_HDR_DATA, {$urandom, $urandom});
            checks++;
            if (out_data !== exp_word || out_valid !== exp_valid || in_ready !== exp_ready || err !== exp_err) begin
                fails++;
                $display("FAIL idle[%0d]: data=%h valid=%b ready=%b err=%b, want %h %b %b %b",
                         c, out_data, out_valid, in_ready, err, exp_word, exp_valid, exp_ready, exp_err);
            end
            if (c >= 7 && c < 12) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL idle_gap[%0d]: valid=%b ready=%b, want 0 1", c, out_valid, in_ready);
                end
            end
        end
    endtask

    task automatic test_drain_violation();
        logic [CNT_W-1:0] want_cnt;
`ifdef PCS_TXGB_ERRCNT_EN
        want_cnt = 1;
`else
        want_cnt = 0;
`endif
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, 1'b1, PCS_HDR_DATA, {$urandom, $urandom});
            checks++;
            if (out_data !== exp_word || out_valid !== exp_valid || in_ready !== exp_ready || err !== exp_err || err_cnt !== exp_cnt) begin
                fails++;
                $display("FAIL viol[%0d]: data=%h valid=%b ready=%b err=%b cnt=%0d, want %h %b %b %b %0d",
                         i, out_data, out_valid, in_ready, err, err_cnt, exp_word, exp_valid, exp_ready, exp_err, exp_cnt);
            end
        end
        checks++;
        if (err !== 1'b1 || err_cnt !== want_cnt || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL viol_flag: err=%b cnt=%0d ready=%b, want 1 %0d 1", err, err_cnt, in_ready, want_cnt);
        end
    endtask

    task automatic test_enable_hold();
        logic [63:0] held;
        held = 64'h0;
        for (int c = 0; c < 36; c++) begin
            drive(!(c >= 31 && c < 34), c != 35, PCS_HDR_CTRL, {$urandom, $urandom});
            checks++;
            if (out_data !== exp_word || out_valid !== exp_valid || in_ready !== exp_ready || err !== exp_err) begin
                fails++;
                $display("FAIL enable[%0d]: data=%h valid=%b ready=%b err=%b, want %h %b %b %b",
                         c, out_data, out_valid, in_ready, err, exp_word, exp_valid, exp_ready, exp_err);
            end
            if (c == 30) held = out_data;
            if (c >= 31 && c < 34) begin
                checks++;
                if (out_valid !== 1'b0 || out_data !== held) begin
                    fails++;
                    $display("FAIL enable_hold[%0d]: valid=%b data=%h, want 0 %h", c, out_valid, out_data, held);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, PCS_HDR_DATA, {$urandom, $urandom});
        reset_n = 1'b0;
        drive(1'b1, 1'b1, PCS_HDR_DATA, {$urandom, $urandom});
        reset_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0 || err_cnt !== '0) begin
            fails++;
            $display("FAIL midreset: ready=%b valid=%b err=%b cnt=%0d, want 1 0 0 0", in_ready, out_valid, err, err_cnt);
        end
        d = {$urandom, $urandom};
        drive(1'b1, 1'b1, PCS_HDR_CTRL, d);
        checks++;
        if (out_data !== {d[61:0], PCS_HDR_CTRL} || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL midreset_first: data=%h valid=%b, want %h 1", out_data, out_valid, {d[61:0], PCS_HDR_CTRL});
        end
        for (int i = 1; i < 33; i++) begin
            drive(1'b1, i < 32, PCS_HDR_DATA, {$urandom, $urandom});
            checks++;
            if (out_data !== exp_word || out_valid !== exp_valid || in_ready !== exp_ready) begin
                fails++;
                $display("FAIL midreset_seq[%0d]: data=%h valid=%b ready=%b, want %h %b %b",
                         i, out_data, out_valid, in_ready, exp_word, exp_valid, exp_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) == 1) ? PCS_HDR_CTRL : PCS_HDR_DATA, {$urandom, $urandom});
            checks++;
            if (out_data !== exp_word || out_valid !== exp_valid || in_ready !== exp_ready || err !== exp_err || err_cnt !== exp_cnt) begin
                fails++;
                $display("FAIL random[%0d]: data=%h valid=%b ready=%b err=%b cnt=%0d, want %h %b %b %b %0d",
                         c, out_data, out_valid, in_ready, err, err_cnt, exp_word, exp_valid, exp_ready, exp_err, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_blocks();
        test_incrementing();
        test_idle_gap();
        test_drain_violation();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
